// File: rtl/ternary_pkg.sv
// Purpose: shared trit encodings and per-trit arithmetic helpers for the ternary datapath.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Trit encoding is 2 bits per trit: 00 = 0, 01 = +1, 10 = -1, 11 = illegal.
package ternary_pkg;

  localparam logic [1:0] T_ZERO = 2'b00;
  localparam logic [1:0] T_POS  = 2'b01;
  localparam logic [1:0] T_NEG  = 2'b10;
  localparam logic [1:0] T_ILL  = 2'b11;

  // Negation in balanced ternary is a swap of the two code bits; 00 maps to itself.
  function automatic logic [1:0] tritNeg(input logic [1:0] t);
    return {t[0], t[1]};
  endfunction

  // The illegal code is read as zero; the caller flags it separately.
  function automatic logic [1:0] tritClean(input logic [1:0] t);
    return (t == T_ILL) ? T_ZERO : t;
  endfunction

  function automatic logic signed [2:0] tritVal(input logic [1:0] t);
    case (t)
      T_POS:   return 3'sd1;
      T_NEG:   return -3'sd1;
      default: return 3'sd0;
    endcase
  endfunction

  function automatic logic [1:0] tritEnc(input logic signed [2:0] v);
    if (v > 3'sd0) return T_POS;
    if (v < 3'sd0) return T_NEG;
    return T_ZERO;
  endfunction

  // Returns {carry, digit}. The raw sum spans -3..+3; anything outside -1..+1
  // is folded back by +/-3 with the matching carry.
  function automatic logic [3:0] tritFullAdd(input logic [1:0] a, input logic [1:0] b,
                                             input logic [1:0] c);
    logic signed [2:0] t;
    logic signed [2:0] d;
    logic [1:0]        carry;
    t = tritVal(a) + tritVal(b) + tritVal(c);
    if (t > 3'sd1) begin
      d     = t - 3'sd3;
      carry = T_POS;
    end else if (t < -3'sd1) begin
      d     = t + 3'sd3;
      carry = T_NEG;
    end else begin
      d     = t;
      carry = T_ZERO;
    end
    return {carry, tritEnc(d)};
  endfunction

endpackage

// File: rtl/ternary_chunk_adder.sv
// Purpose: C-trit balanced-ternary ripple adder, one pipeline chunk.
// Latency: combinational.
// Backpressure: none (pure logic).
// Ports: a, b (2*C bits, legal trits only), cIn (carry trit) -> s (2*C bits), cOut (carry trit).
module ternary_chunk_adder
  import ternary_pkg::*;
#(
  parameter int C = 4
) (
  input  logic [2*C-1:0] a,
  input  logic [2*C-1:0] b,
  input  logic [1:0]     cIn,
  output logic [2*C-1:0] s,
  output logic [1:0]     cOut
);

  logic [1:0] carry;
  logic [3:0] r;

  always_comb begin
    carry = cIn;
    r     = '0;
    s     = '0;
    for (int i = 0; i < C; i++) begin
      r            = tritFullAdd(a[2*i +: 2], b[2*i +: 2], carry);
      s[2*i +: 2]  = r[1:0];
      carry        = r[3:2];
    end
    cOut = carry;
  end

endmodule

// File: rtl/ternary_pipe_adder.sv
// Purpose: pipelined N-trit balanced-ternary add/subtract, one N/STAGES-trit chunk per stage.
// Latency: STAGES cycles from acceptance to outValid; one result per cycle.
// Backpressure: global stall; every stage holds while outValid & ~outReady (inReady = advance).
// Ports: clk, resetN (async active-low); inValid/inReady with a, b, cIn, sub;
//        outValid/outReady with s, cOut, zero, sign, err. N must be a multiple of STAGES.
module ternary_pipe_adder
  import ternary_pkg::*;
#(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           resetN,
  input  logic           inValid,
  output logic           inReady,
  input  logic [2*N-1:0] a,
  input  logic [2*N-1:0] b,
  input  logic [1:0]     cIn,
  input  logic           sub,
  output logic           outValid,
  input  logic           outReady,
  output logic [2*N-1:0] s,
  output logic [1:0]     cOut,
  output logic           zero,
  output logic [1:0]     sign,
  output logic           err
);

  localparam int W  = 2 * N;
  localparam int C  = N / STAGES;
  localparam int CW = 2 * C;

  logic adv;

  // The pipeline never collapses bubbles: it moves as a whole or not at all.
  assign adv     = ~outValid | outReady;
  assign inReady = adv;

  // Operand conditioning: illegal trits become zero, b is negated for subtract.
  logic [W-1:0] aClean;
  logic [W-1:0] bClean;
  logic [1:0]   cInClean;
  logic         inErr;

  assign cInClean = tritClean(cIn);

  always_comb begin
    aClean = '0;
    bClean = '0;
    inErr  = (cIn == T_ILL);
    for (int i = 0; i < N; i++) begin
      aClean[2*i +: 2] = tritClean(a[2*i +: 2]);
      bClean[2*i +: 2] = sub ? tritNeg(tritClean(b[2*i +: 2])) : tritClean(b[2*i +: 2]);
      inErr            = inErr | (a[2*i +: 2] == T_ILL) | (b[2*i +: 2] == T_ILL);
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    // Operands shrink as they move: stage k still needs trits k*C and above,
    // always presented with its own chunk at the bottom.
    localparam int WI = W - k * CW;

    logic [WI-1:0] aIn;
    logic [WI-1:0] bIn;
    logic [W-1:0]  sumIn;
    logic [W-1:0]  sumNext;
    logic [W-1:0]  sumQ;
    logic [1:0]    carryIn;
    logic [1:0]    carryQ;
    logic [1:0]    chunkCarry;
    logic [CW-1:0] chunkSum;
    logic          vldIn;
    logic          errIn;
    logic          vldQ;
    logic          errQ;

    if (k == 0) begin : gHead
      assign aIn     = aClean;
      assign bIn     = bClean;
      assign carryIn = cInClean;
      assign vldIn   = inValid;
      assign errIn   = inErr;
      assign sumIn   = '0;
    end else begin : gBody
      assign aIn     = gStage[k-1].gSkew.aQ;
      assign bIn     = gStage[k-1].gSkew.bQ;
      assign carryIn = gStage[k-1].carryQ;
      assign vldIn   = gStage[k-1].vldQ;
      assign errIn   = gStage[k-1].errQ;
      assign sumIn   = gStage[k-1].sumQ;
    end

    ternary_chunk_adder #(.C(C)) uChunk (
      .a    (aIn[CW-1:0]),
      .b    (bIn[CW-1:0]),
      .cIn  (carryIn),
      .s    (chunkSum),
      .cOut (chunkCarry)
    );

    // Lower result trits pass through untouched; this stage fills in its own chunk.
    always_comb begin
      sumNext               = sumIn;
      sumNext[k*CW +: CW]   = chunkSum;
    end

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        vldQ   <= 1'b0;
        errQ   <= 1'b0;
        carryQ <= T_ZERO;
        sumQ   <= '0;
      end else if (adv) begin
        vldQ   <= vldIn;
        errQ   <= errIn;
        carryQ <= chunkCarry;
        sumQ   <= sumNext;
      end
    end

    if (k < STAGES - 1) begin : gSkew
      logic [WI-CW-1:0] aQ;
      logic [WI-CW-1:0] bQ;

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          aQ <= '0;
          bQ <= '0;
        end else if (adv) begin
          aQ <= aIn[WI-1:CW];
          bQ <= bIn[WI-1:CW];
        end
      end
    end
  end

  // Result flags are derived from the complete sum as it enters the output register.
  logic [W-1:0] finalSum;
  logic [1:0]   signNext;
  logic         zeroNext;
  logic         zeroQ;
  logic [1:0]   signQ;

  assign finalSum = gStage[STAGES-1].sumNext;
  assign zeroNext = (finalSum == '0);

  // Scanning upward leaves the most significant nonzero trit in signNext.
  always_comb begin
    signNext = T_ZERO;
    for (int i = 0; i < N; i++) begin
      if (finalSum[2*i +: 2] != T_ZERO) signNext = finalSum[2*i +: 2];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      zeroQ <= 1'b1;
      signQ <= T_ZERO;
    end else if (adv) begin
      zeroQ <= zeroNext;
      signQ <= signNext;
    end
  end

  assign outValid = gStage[STAGES-1].vldQ;
  assign s        = gStage[STAGES-1].sumQ;
  assign cOut     = gStage[STAGES-1].carryQ;
  assign err      = gStage[STAGES-1].errQ;
  assign zero     = zeroQ;
  assign sign     = signQ;

endmodule
